rggen_access_arbiter: RTL and testbench

- Shares one register-block software access port among HOSTS requesters. The port is the path that drives the bit-field sw valid/write-enable/mask/data inputs and returns read data.
- Uses round-robin arbitration with one outstanding access at a time.
- Sits between the bus-protocol adapters and the register/bit-field array.
- Owns the request → access → response sequencing.

---
 rtl/rggen_access_arbiter_pkg.sv | 28 ++
 rtl/rggen_round_robin_grant.sv | 50 +++++
 rtl/rggen_access_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rggen_access_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_access_arbiter_pkg.sv
// Shared definitions for the register-block access arbiter.
//   - FSM state encodings and response status codes (as macros, so that
//     other RTL in the slice can use the same literal values)
//   - typed FSM state enum built from those encodings
//   - helper that sizes host-index fields (at least one bit, even for one host)
`ifndef RGGEN_RTL_MACROS_VH
`define RGGEN_RTL_MACROS_VH
`define RGGEN_ARBITER_IDLE        2'b00
`define RGGEN_ARBITER_ACCESS      2'b01
`define RGGEN_ARBITER_RESPONSE    2'b10
`define RGGEN_STATUS_OKAY         2'b00
`define RGGEN_STATUS_SLAVE_ERROR  2'b10
`endif

package rggen_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ARBITER_IDLE     = `RGGEN_ARBITER_IDLE,
        ARBITER_ACCESS   = `RGGEN_ARBITER_ACCESS,
        ARBITER_RESPONSE = `RGGEN_ARBITER_RESPONSE
    } rggen_arbiter_state_e;

    // Width of a host index; a single host still gets a 1-bit field.
    function automatic int rggen_index_width(input int hosts);
        return (hosts > 1) ? $clog2(hosts) : 1;
    endfunction

endpackage

// File: rtl/rggen_round_robin_grant.sv
// Combinational round-robin grant.
//   i_request : request vector, one bit per requester
//   i_pointer : index where the upward scan starts (highest priority)
//   o_grant   : one-hot grant, zero when nothing is requested
//   o_index   : encoded index of the granted requester (0 when no grant)
// The scan starts at i_pointer, moves upward and wraps to 0.
module rggen_round_robin_grant
    import rggen_access_arbiter_pkg::*;
#(
    parameter int REQUESTS    = 2,
    parameter int INDEX_WIDTH = rggen_index_width(REQUESTS)
)(
    input  logic [REQUESTS-1:0]    i_request,
    input  logic [INDEX_WIDTH-1:0] i_pointer,
    output logic [REQUESTS-1:0]    o_grant,
    output logic [INDEX_WIDTH-1:0] o_index
);

    logic [REQUESTS-1:0]    grant_s;
    logic [INDEX_WIDTH-1:0] index_s;
    logic                   found_s;
    int                     slot_s;

    // Scan requesters from the pointer upward with wrap; the first hit wins.
    always_comb begin
        grant_s = '0;
        index_s = '0;
        found_s = 1'b0;
        slot_s  = 0;
        for (int i = 0; i < REQUESTS; i++) begin
            slot_s = int'(i_pointer) + i;
            if (slot_s >= REQUESTS) begin
                slot_s = slot_s - REQUESTS;
            end else begin
                slot_s = slot_s;
            end
            if (!found_s && i_request[slot_s]) begin
                grant_s[slot_s] = 1'b1;
                index_s         = INDEX_WIDTH'(slot_s);
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign o_grant = grant_s;
    assign o_index = index_s;

endmodule

// File: rtl/rggen_access_arbiter.sv
// Round-robin arbiter sharing one register-block software access port
// among HOSTS requesters, with a single access outstanding at a time.
//   i_clk / i_rst_n       : clock, asynchronous active-low reset
//   i_req_* / o_req_ready : per-host request channel (payloads packed per host)
//   o_rsp_* / i_rsp_ready : per-host response channel (data/status shared)
//   o_access_* / i_access_* : downstream access towards the bit-field array
// Sequence: IDLE (grant + latch) -> ACCESS (wait i_access_ready) ->
// RESPONSE (wait i_rsp_ready of the granted host) -> IDLE.
module rggen_access_arbiter
    import rggen_access_arbiter_pkg::*;
#(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int STROBE_WIDTH  = BUS_WIDTH / 8
)(
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [HOSTS-1:0]                i_req_valid,
    output logic [HOSTS-1:0]                o_req_ready,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0]  i_req_address,
    input  logic [HOSTS-1:0]                i_req_write,
    input  logic [HOSTS*BUS_WIDTH-1:0]      i_req_write_data,
    input  logic [HOSTS*STROBE_WIDTH-1:0]   i_req_strobe,
    output logic [HOSTS-1:0]                o_rsp_valid,
    input  logic [HOSTS-1:0]                i_rsp_ready,
    output logic [BUS_WIDTH-1:0]            o_rsp_read_data,
    output logic [1:0]                      o_rsp_status,
    output logic                            o_access_valid,
    input  logic                            i_access_ready,
    output logic [ADDRESS_WIDTH-1:0]        o_access_address,
    output logic                            o_access_write,
    output logic [BUS_WIDTH-1:0]            o_access_write_data,
    output logic [STROBE_WIDTH-1:0]         o_access_strobe,
    input  logic [BUS_WIDTH-1:0]            i_access_read_data,
    input  logic [1:0]                      i_access_status
);

    localparam int INDEX_WIDTH = rggen_index_width(HOSTS);

    rggen_arbiter_state_e       state_r;
    logic [INDEX_WIDTH-1:0]     pointer_r;
    logic [INDEX_WIDTH-1:0]     index_r;
    logic [INDEX_WIDTH-1:0]     next_pointer_s;
    logic [INDEX_WIDTH-1:0]     grant_index_s;
    logic [HOSTS-1:0]           grant_s;
    logic [HOSTS-1:0]           req_ready_s;
    logic [HOSTS-1:0]           rsp_onehot_s;
    logic [HOSTS-1:0]           rsp_valid_r;
    logic                       access_valid_r;
    logic [ADDRESS_WIDTH-1:0]   address_r;
    logic                       write_r;
    logic [BUS_WIDTH-1:0]       write_data_r;
    logic [STROBE_WIDTH-1:0]    strobe_r;
    logic [BUS_WIDTH-1:0]       read_data_r;
    logic [1:0]                 status_r;
    logic [ADDRESS_WIDTH-1:0]   sel_address_s;
    logic                       sel_write_s;
    logic [BUS_WIDTH-1:0]       sel_write_data_s;
    logic [STROBE_WIDTH-1:0]    sel_strobe_s;

    generate
        if (HOSTS == 1) begin : g_single_host
            // Only one requester: no arbitration, pointer never moves.
            assign grant_s        = i_req_valid;
            assign grant_index_s  = '0;
            assign next_pointer_s = '0;
        end else begin : g_multi_host
            rggen_round_robin_grant #(
                .REQUESTS    (HOSTS),
                .INDEX_WIDTH (INDEX_WIDTH)
            ) u_grant (
                .i_request (i_req_valid),
                .i_pointer (pointer_r),
                .o_grant   (grant_s),
                .o_index   (grant_index_s)
            );
            // The host after the one just served gets first priority next.
            assign next_pointer_s = (index_r == INDEX_WIDTH'(HOSTS - 1))
                                  ? '0 : index_r + INDEX_WIDTH'(1);
        end
    endgenerate

    // Select the granted host's payload for latching.
    always_comb begin
        sel_address_s    = i_req_address[int'(grant_index_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write_s      = i_req_write[grant_index_s];
        sel_write_data_s = i_req_write_data[int'(grant_index_s)*BUS_WIDTH +: BUS_WIDTH];
        sel_strobe_s     = i_req_strobe[int'(grant_index_s)*STROBE_WIDTH +: STROBE_WIDTH];
    end

    // Request ready is the grant, only while idle and out of reset so that
    // no acceptance is signalled while the reset is holding the FSM.
    always_comb begin
        req_ready_s = '0;
        if ((state_r == ARBITER_IDLE) && i_rst_n) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // One-hot response valid for the latched host index.
    always_comb begin
        rsp_onehot_s = '0;
        for (int h = 0; h < HOSTS; h++) begin
            rsp_onehot_s[h] = (index_r == INDEX_WIDTH'(h));
        end
    end

    // Arbiter FSM with registered access and response outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r        <= ARBITER_IDLE;
            pointer_r      <= '0;
            index_r        <= '0;
            access_valid_r <= 1'b0;
            address_r      <= '0;
            write_r        <= 1'b0;
            write_data_r   <= '0;
            strobe_r       <= '0;
            rsp_valid_r    <= '0;
            read_data_r    <= '0;
            status_r       <= 2'b00;
        end else begin
            case (state_r)
                ARBITER_IDLE: begin
                    if (|grant_s) begin
                        index_r        <= grant_index_s;
                        address_r      <= sel_address_s;
                        write_r        <= sel_write_s;
                        write_data_r   <= sel_write_data_s;
                        strobe_r       <= sel_strobe_s;
                        access_valid_r <= 1'b1;
                        state_r        <= ARBITER_ACCESS;
                    end else begin
                        state_r <= ARBITER_IDLE;
                    end
                end
                ARBITER_ACCESS: begin
                    // No timeout: the downstream side owns completion.
                    if (i_access_ready) begin
                        read_data_r    <= i_access_read_data;
                        status_r       <= i_access_status;
                        access_valid_r <= 1'b0;
                        rsp_valid_r    <= rsp_onehot_s;
                        state_r        <= ARBITER_RESPONSE;
                    end else begin
                        state_r <= ARBITER_ACCESS;
                    end
                end
                ARBITER_RESPONSE: begin
                    // Only the granted host's ready completes the response.
                    if (i_rsp_ready[index_r]) begin
                        rsp_valid_r <= '0;
                        pointer_r   <= next_pointer_s;
                        state_r     <= ARBITER_IDLE;
                    end else begin
                        state_r <= ARBITER_RESPONSE;
                    end
                end
                default: begin
                    access_valid_r <= 1'b0;
                    rsp_valid_r    <= '0;
                    state_r        <= ARBITER_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready         = req_ready_s;
    assign o_rsp_valid         = rsp_valid_r;
    assign o_rsp_read_data     = read_data_r;
    assign o_rsp_status        = status_r;
    assign o_access_valid      = access_valid_r;
    assign o_access_address    = address_r;
    assign o_access_write      = write_r;
    assign o_access_write_data = write_data_r;
    assign o_access_strobe     = strobe_r;

endmodule

// File: tb/tb_rggen_access_arbiter.sv
// Self-checking bench for rggen_access_arbiter with four hosts.
module tb_rggen_access_arbiter;

    localparam int H  = 4;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [H-1:0]    req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [H*AW-1:0] req_address;
    logic [H*BW-1:0] req_wdata;
    logic [H*SW-1:0] req_strobe;
    logic [BW-1:0]   rsp_rdata;
    logic [1:0]      rsp_status;
    logic            acc_valid, acc_ready, acc_write;
    logic [AW-1:0]   acc_addr;
    logic [BW-1:0]   acc_wdata, acc_rdata;
    logic [SW-1:0]   acc_strobe;
    logic [1:0]      acc_status;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    logic [AW-1:0] h_addr [H];
    logic          h_wr   [H];
    logic [BW-1:0] h_wd   [H];
    logic [SW-1:0] h_sb   [H];

    typedef struct {
        logic [H-1:0] mask;
        int           win;
        int           lat;
        int           bp;
        logic [BW-1:0] rd;
        logic [1:0]   st;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    rggen_access_arbiter #(
        .HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_req_valid         (req_valid),
        .o_req_ready         (req_ready),
        .i_req_address       (req_address),
        .i_req_write         (req_write),
        .i_req_write_data    (req_wdata),
        .i_req_strobe        (req_strobe),
        .o_rsp_valid         (rsp_valid),
        .i_rsp_ready         (rsp_ready),
        .o_rsp_read_data     (rsp_rdata),
        .o_rsp_status        (rsp_status),
        .o_access_valid      (acc_valid),
        .i_access_ready      (acc_ready),
        .o_access_address    (acc_addr),
        .o_access_write      (acc_write),
        .o_access_write_data (acc_wdata),
        .o_access_strobe     (acc_strobe),
        .i_access_read_data  (acc_rdata),
        .i_access_status     (acc_status)
    );

    task automatic chk(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, name, act, exp);
        end
    endtask

    // Round-robin reference: first requester at or above ptr, wrapping.
    function automatic int rr_pick(input logic [H-1:0] mask, input int ptr);
        for (int k = 0; k < H; k++) begin
            if (mask[(ptr + k) % H]) return (ptr + k) % H;
        end
        return -1;
    endfunction

    task automatic drive_hosts(input logic [H-1:0] mask);
        req_valid = mask;
        for (int h = 0; h < H; h++) begin
            req_address[h*AW +: AW] = h_addr[h];
            req_write[h]            = h_wr[h];
            req_wdata[h*BW +: BW]   = h_wd[h];
            req_strobe[h*SW +: SW]  = h_sb[h];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, "req_ready", req_ready, 0);
        chk(tag, "rsp_valid", rsp_valid, 0);
        chk(tag, "rsp_rdata", rsp_rdata, 0);
        chk(tag, "rsp_status", rsp_status, 0);
        chk(tag, "acc_valid", acc_valid, 0);
        chk(tag, "acc_addr", acc_addr, 0);
        chk(tag, "acc_write", acc_write, 0);
        chk(tag, "acc_wdata", acc_wdata, 0);
        chk(tag, "acc_strobe", acc_strobe, 0);
    endtask

    task automatic chk_payload(input string tag, input int w);
        chk(tag, "acc_addr", acc_addr, h_addr[w]);
        chk(tag, "acc_write", acc_write, h_wr[w]);
        chk(tag, "acc_wdata", acc_wdata, h_wd[w]);
        chk(tag, "acc_strobe", acc_strobe, h_sb[w]);
    endtask

    // One full accept/access/response transaction; entered just after a
    // clock edge with the DUT idle, leaves just after the handshake edge.
    task automatic txn(input string tag, input logic [H-1:0] mask, input int w,
                       input int lat, input int bp,
                       input logic [BW-1:0] rd, input logic [1:0] st);
        logic [H-1:0] onehot;
        onehot    = '0;
        onehot[w] = 1'b1;
        drive_hosts(mask);
        #1;
        chk(tag, "grant", req_ready, onehot);
        chk(tag, "idle_acc_valid", acc_valid, 0);
        chk(tag, "idle_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        #1;
        chk(tag, "acc_valid_lat1", acc_valid, 1);
        chk(tag, "busy_req_ready", req_ready, 0);
        chk_payload(tag, w);
        for (int c = 0; c < lat; c++) begin
            req_address[w*AW +: AW] = AW'($urandom);
            req_write[w]            = ~h_wr[w];
            req_wdata[w*BW +: BW]   = $urandom;
            req_strobe[w*SW +: SW]  = SW'($urandom);
            @(posedge clk); #1;
            chk(tag, "acc_valid_hold", acc_valid, 1);
            chk(tag, "wait_req_ready", req_ready, 0);
            chk_payload(tag, w);
        end
        acc_ready  = 1'b1;
        acc_rdata  = rd;
        acc_status = st;
        @(posedge clk); #1;
        acc_ready  = 1'b0;
        acc_rdata  = $urandom;
        acc_status = 2'($urandom);
        #1;
        chk(tag, "acc_valid_drop", acc_valid, 0);
        chk(tag, "rsp_valid", rsp_valid, onehot);
        chk(tag, "rsp_rdata", rsp_rdata, rd);
        chk(tag, "rsp_status", rsp_status, st);
        chk(tag, "rsp_req_ready", req_ready, 0);
        for (int c = 0; c < bp; c++) begin
            rsp_ready = H'($urandom) & ~onehot;
            @(posedge clk); #1;
            chk(tag, "bp_rsp_valid", rsp_valid, onehot);
            chk(tag, "bp_rsp_rdata", rsp_rdata, rd);
            chk(tag, "bp_rsp_status", rsp_status, st);
            chk(tag, "bp_req_ready", req_ready, 0);
        end
        rsp_ready = onehot;
        @(posedge clk); #1;
        rsp_ready = '0;
        chk(tag, "rsp_done", rsp_valid, 0);
        model_ptr = (w + 1) % H;
    endtask

    initial begin
        logic [H-1:0] pending;
        int           w;

        h_addr[0] = 8'h10; h_wr[0] = 1'b0; h_wd[0] = 32'h0;         h_sb[0] = 4'b1111;
        h_addr[1] = 8'h20; h_wr[1] = 1'b1; h_wd[1] = 32'h0000_55AA; h_sb[1] = 4'b0011;
        h_addr[2] = 8'h30; h_wr[2] = 1'b0; h_wd[2] = 32'h0;         h_sb[2] = 4'b1111;
        h_addr[3] = 8'h40; h_wr[3] = 1'b1; h_wd[3] = 32'h1234_5678; h_sb[3] = 4'b1111;

        tbl[0]  = '{4'b0011, 0, 1, 0, 32'hA0A0_0001, 2'b00};
        tbl[1]  = '{4'b0011, 1, 3, 5, 32'h0000_0000, 2'b00};
        tbl[2]  = '{4'b0011, 0, 0, 1, 32'hA0A0_0003, 2'b10};
        tbl[3]  = '{4'b0011, 1, 2, 0, 32'h0000_0000, 2'b10};
        tbl[4]  = '{4'b0100, 2, 1, 2, 32'hC2C2_0005, 2'b00};
        tbl[5]  = '{4'b1001, 3, 0, 0, 32'h0000_0000, 2'b00};
        tbl[6]  = '{4'b1001, 0, 1, 0, 32'h1111_2222, 2'b00};
        tbl[7]  = '{4'b1111, 1, 1, 1, 32'h0000_0000, 2'b10};
        tbl[8]  = '{4'b0001, 0, 2, 0, 32'hFFFF_FFFF, 2'b10};
        tbl[9]  = '{4'b1100, 2, 0, 3, 32'h0000_0000, 2'b00};
        tbl[10] = '{4'b0110, 1, 1, 0, 32'h0000_0000, 2'b00};
        tbl[11] = '{4'b1000, 3, 1, 1, 32'h0000_0000, 2'b00};

        rst_n      = 1'b0;
        rsp_ready  = '0;
        acc_ready  = 1'b0;
        acc_rdata  = '0;
        acc_status = 2'b00;
        drive_hosts(4'b1111);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;
        drive_hosts(4'b0000);
        @(posedge clk); #1;
        chk("no_request", "req_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("no_request", "acc_valid", acc_valid, 0);

        txn("single_read", 4'b0001, 0, 2, 0, 32'hDEAD_BEEF, 2'b00);

        // Reset in the middle of an access (pointer is 1 here).
        drive_hosts(4'b0110);
        #1;
        chk("mid_reset", "grant_ptr1", req_ready, 4'b0010);
        @(posedge clk); #1;
        chk("mid_reset", "acc_valid", acc_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive_hosts(4'b1111);
        #1;
        chk("after_reset", "grant_ptr0", req_ready, 4'b0001);
        req_valid = '0;
        @(posedge clk); #1;
        chk("after_reset", "rsp_valid", rsp_valid, 0);
        chk("after_reset", "acc_valid", acc_valid, 0);
        model_ptr = 0;

        for (int i = 0; i < 12; i++) begin
            txn($sformatf("vec%0d", i), tbl[i].mask, tbl[i].win,
                tbl[i].lat, tbl[i].bp, tbl[i].rd, tbl[i].st);
        end

        pending = '0;
        for (int n = 0; n < 60; n++) begin
            for (int h = 0; h < H; h++) begin
                if (!pending[h] && ($urandom_range(0, 1) == 1)) begin
                    pending[h] = 1'b1;
                    h_addr[h]  = AW'($urandom);
                    h_wr[h]    = 1'($urandom);
                    h_wd[h]    = $urandom;
                    h_sb[h]    = SW'($urandom);
                end
            end
            if (pending == '0) begin
                w          = $urandom_range(0, H - 1);
                pending[w] = 1'b1;
            end
            w = rr_pick(pending, model_ptr);
            txn($sformatf("rand%0d", n), pending, w,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00);
            pending[w] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
